ecliptic_fp_misc_unit: RTL and testbench
========================================

Name: ecliptic_fp_misc_unit

Overview:
- Single-precision (IEEE 754 binary32) miscellaneous FP unit for the ecliptic FPU, combining three functions on the same operands:
  - sign injection (FSGNJ/FSGNJN/FSGNJX)
  - classification (FCLASS)
  - comparison and min/max (FLT/FLE/FEQ/FMIN/FMAX)
- Results are registered, one-cycle latency, with a simple req/ack handshake.
- Sits beside the arithmetic datapath in the FPU execute stage.

Parameters:
- None. Width is fixed at 32 bits (binary32).

Ports:
- clk      input   1   clock; all registers on rising edge
- nrst     input   1   reset, asynchronous, active-high (1 = reset asserted)
- req      input   1   operands valid this cycle
- src1     input   32  operand 1 (binary32)
- src2     input   32  operand 2 (binary32)
- op       input   2   sign-injection select: 00 SGNJ, 01 SGNJN, 10 SGNJX, 11 pass src1
- ack      output  1   results valid
- res      output  32  sign-injection result
- cls      output  10  class one-hot: bit9 qNaN, bit8 sNaN, bit7 +inf, bit6 +normal, bit5 +subnormal, bit4 +0, bit3 -0, bit2 -subnormal, bit1 -normal, bit0 -inf
- minimum  output  32  min(src1, src2)
- maximum  output  32  max(src1, src2)
- lt       output  1   src1 < src2
- eq       output  1   src1 == src2
- le       output  1   src1 <= src2

Behaviour:
- Reset (nrst=1, asynchronous): ack, res, cls, minimum, maximum, lt, eq, le all 0. Reset mid-operation discards the in-flight result.
- Handshake:
  - ack <= req each cycle, so ack is high exactly one cycle after each req-high cycle.
  - Back-to-back req is supported with throughput 1/cycle.
  - When req=0, all result registers hold their previous values.
- Sign injection: res = {s, src1[30:0]}, where s is:
  - op 00: src2[31]
  - op 01: ~src2[31]
  - op 10: src1[31]^src2[31]
  - op 11: src1[31]
  - NaN payloads pass unchanged.
- Classification is on src1 only; exactly one bit is set. With e = src1[30:23] and f = src1[22:0]:
  - e=FF, f=0: ±inf
  - e=FF, f≠0: NaN. f[22]=1 gives qNaN, else sNaN; sign is ignored.
  - e=0, f=0: ±0
  - e=0, f≠0: ±subnormal
  - otherwise: ±normal
- Compare (lt/eq/le):
  - If either operand is NaN (q or s), lt=eq=le=0.
  - +0 and -0 compare equal (eq=1, le=1, lt=0).
  - Otherwise ordering is sign-magnitude:
    - signs differ: negative is smaller
    - both positive: compare [30:0] unsigned
    - both negative: the larger [30:0] is smaller
  - le = lt | eq.
- Min/max:
  - Both operands NaN: minimum = maximum = 32'h7fc00000 (canonical qNaN).
  - Exactly one NaN: both outputs return the non-NaN operand.
  - Zeros: -0 is treated as less than +0, so min(+0,-0) = 80000000 and max = 00000000.
  - Otherwise the ordering above is used; on equality, return src1.
- All four result groups update together on a req cycle; op affects only res.

Optional Feature:
- Macro ECLIPTIC_FP_FLAGS_EN adds output port nv (1 bit, invalid-operation flag).
- nv is registered with the other results, resets to 0, and holds when req=0.
- nv=1 when either of these holds:
  - either operand is sNaN (applies to eq and min/max)
  - either operand is any NaN (applies to lt/le)
- So nv = sNaN(src1)|sNaN(src2)|NaN(src1)|NaN(src2), which reduces to NaN(src1)|NaN(src2).
- Without the macro, the nv port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert nrst=1 mid-stream with req=1 → all outputs read 0 immediately and stay 0 until release; first ack comes one cycle after the first post-reset req.
- src1=3f800000, src2=cf800000, op=00, req=1 → next cycle ack=1:
  - res=bf800000
  - cls=0x040
  - minimum=cf800000, maximum=3f800000
  - lt=0, eq=0, le=0
- src1=7fc00000, src2=3f800000, op=00 → next cycle:
  - res=7fc00000
  - cls=0x200
  - minimum=maximum=3f800000
  - lt=eq=le=0
  - nv=1 if ECLIPTIC_FP_FLAGS_EN
- src1=80000000, src2=00000000 → next cycle:
  - cls=0x008
  - minimum=80000000, maximum=00000000
  - eq=1, le=1, lt=0
  - op=10 gives res=80000000
- src1=7f800001, src2=ffc00000 → next cycle:
  - cls=0x100
  - minimum=maximum=7fc00000
  - lt=eq=le=0
- Negative ordering and hold: src1=c0000000 (-2), src2=bf800000 (-1), then req=0 for 3 cycles:
  - on the ack cycle: lt=1, le=1, minimum=c0000000, maximum=bf800000
  - ack drops to 0 and all outputs hold for the 3 idle cycles.

Source files
------------

// File: rtl/ecliptic_fp_misc_unit.sv
// Binary32 sign-injection, classification, compare and min/max unit with one-cycle registered results.
// Optional invalid-operation flag output nv is enabled by defining ECLIPTIC_FP_FLAGS_EN.
module ecliptic_fp_misc_unit (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [1:0]  op,
    output logic        ack,
    output logic [31:0] res,
    output logic [9:0]  cls,
    output logic [31:0] minimum,
    output logic [31:0] maximum,
    output logic        lt,
    output logic        eq,
`ifdef ECLIPTIC_FP_FLAGS_EN
    output logic        nv,
`endif
    output logic        le
);

    localparam int unsigned DataW = 32;
    localparam int unsigned ExpW  = 8;
    localparam int unsigned FracW = 23;
    localparam int unsigned ClsW  = 10;
    localparam logic [DataW-1:0] CanonNan = 32'h7fc0_0000;

    // Field decode for both operands
    logic             sign1, sign2;
    logic [ExpW-1:0]  exp1, exp2;
    logic [FracW-1:0] frac1, frac2;
    logic [DataW-2:0] mag1, mag2;

    assign sign1 = src1[31];
    assign sign2 = src2[31];
    assign exp1  = src1[30:23];
    assign exp2  = src2[30:23];
    assign frac1 = src1[22:0];
    assign frac2 = src2[22:0];
    assign mag1  = src1[30:0];
    assign mag2  = src2[30:0];

    logic expMax1, expMax2, expZero1, fracZero1;
    logic isNan1, isNan2, bothZero;

    assign expMax1   = (exp1 == {ExpW{1'b1}});
    assign expMax2   = (exp2 == {ExpW{1'b1}});
    assign expZero1  = (exp1 == '0);
    assign fracZero1 = (frac1 == '0);
    assign isNan1    = expMax1 && (frac1 != '0);
    assign isNan2    = expMax2 && (frac2 != '0);
    assign bothZero  = (mag1 == '0) && (mag2 == '0);

    // Sign injection
    logic             injSign;
    logic [DataW-1:0] resNext;

    always_comb begin
        injSign = sign1;
        case (op)
            2'b00:   injSign = sign2;
            2'b01:   injSign = ~sign2;
            2'b10:   injSign = sign1 ^ sign2;
            default: injSign = sign1;
        endcase
        resNext = {injSign, mag1};
    end

    // Classification of src1, one-hot
    logic [ClsW-1:0] clsNext;

    always_comb begin
        clsNext = '0;
        if (expMax1) begin
            if (!fracZero1)
                clsNext[frac1[22] ? 9 : 8] = 1'b1;
            else
                clsNext[sign1 ? 0 : 7] = 1'b1;
        end else if (expZero1) begin
            if (fracZero1)
                clsNext[sign1 ? 3 : 4] = 1'b1;
            else
                clsNext[sign1 ? 2 : 5] = 1'b1;
        end else begin
            clsNext[sign1 ? 1 : 6] = 1'b1;
        end
    end

    // Ordered compare: zeros equal regardless of sign, NaN unordered
    logic ordLt, ordEq, anyNan;
    logic ltNext, eqNext, leNext;

    always_comb begin
        ordLt = 1'b0;
        ordEq = (src1 == src2);
        if (bothZero) begin
            ordLt = 1'b0;
            ordEq = 1'b1;
        end else if (sign1 != sign2) begin
            ordLt = sign1;
        end else if (!sign1) begin
            ordLt = (mag1 < mag2);
        end else begin
            ordLt = (mag1 > mag2);
        end
        anyNan = isNan1 || isNan2;
        ltNext = ordLt && !anyNan;
        eqNext = ordEq && !anyNan;
        leNext = ltNext || eqNext;
    end

    // Min/max: -0 orders below +0, ties return src1
    logic             totLt, totEq;
    logic [DataW-1:0] minNext, maxNext;

    always_comb begin
        totLt   = bothZero ? (sign1 && !sign2) : ordLt;
        totEq   = bothZero ? (sign1 == sign2) : ordEq;
        minNext = (!totLt && !totEq) ? src2 : src1;
        maxNext = totLt ? src2 : src1;
        if (isNan1 && isNan2) begin
            minNext = CanonNan;
            maxNext = CanonNan;
        end else if (isNan1) begin
            minNext = src2;
            maxNext = src2;
        end else if (isNan2) begin
            minNext = src1;
            maxNext = src1;
        end
    end

    // Result registers; hold when no request
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            ack     <= 1'b0;
            res     <= '0;
            cls     <= '0;
            minimum <= '0;
            maximum <= '0;
            lt      <= 1'b0;
            eq      <= 1'b0;
            le      <= 1'b0;
        end else begin
            ack <= req;
            if (req) begin
                res     <= resNext;
                cls     <= clsNext;
                minimum <= minNext;
                maximum <= maxNext;
                lt      <= ltNext;
                eq      <= eqNext;
                le      <= leNext;
            end
        end
    end

`ifdef ECLIPTIC_FP_FLAGS_EN
    // Any NaN input is invalid for at least one of the compare/min/max flavours
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst)
            nv <= 1'b0;
        else if (req)
            nv <= anyNan;
    end
`endif

endmodule

// File: tb/tb_ecliptic_fp_misc_unit.sv
// Directed-vector bench for ecliptic_fp_misc_unit with hand-computed expectations.
module tb_ecliptic_fp_misc_unit;

    logic        clk = 1'b0;
    logic        nrst;
    logic        req;
    logic [31:0] src1, src2;
    logic [1:0]  op;
    logic        ack;
    logic [31:0] res;
    logic [9:0]  cls;
    logic [31:0] minimum, maximum;
    logic        lt, eq, le;
`ifdef ECLIPTIC_FP_FLAGS_EN
    logic        nv;
`endif

    int errCnt = 0;
    int chkCnt = 0;

    ecliptic_fp_misc_unit dut (
        .clk     (clk),
        .nrst    (nrst),
        .req     (req),
        .src1    (src1),
        .src2    (src2),
        .op      (op),
        .ack     (ack),
        .res     (res),
        .cls     (cls),
        .minimum (minimum),
        .maximum (maximum),
        .lt      (lt),
        .eq      (eq),
`ifdef ECLIPTIC_FP_FLAGS_EN
        .nv      (nv),
`endif
        .le      (le)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present one request at the falling edge; returns #1 after the capturing edge
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        @(negedge clk);
        src1 = a;
        src2 = b;
        op   = o;
        req  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req = 1'b0;
            src1 = $urandom;
            src2 = $urandom;
            op   = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkAll(input string tag, input logic expAck, input logic [31:0] expRes,
                            input logic [9:0] expCls, input logic [31:0] expMin,
                            input logic [31:0] expMax, input logic expLt, input logic expEq,
                            input logic expLe, input logic expNv);
        checkVal({tag, ".ack"}, 32'(ack), 32'(expAck));
        checkVal({tag, ".res"}, res, expRes);
        checkVal({tag, ".cls"}, 32'(cls), 32'(expCls));
        checkVal({tag, ".min"}, minimum, expMin);
        checkVal({tag, ".max"}, maximum, expMax);
        checkVal({tag, ".lt"}, 32'(lt), 32'(expLt));
        checkVal({tag, ".eq"}, 32'(eq), 32'(expEq));
        checkVal({tag, ".le"}, 32'(le), 32'(expLe));
`ifdef ECLIPTIC_FP_FLAGS_EN
        checkVal({tag, ".nv"}, 32'(nv), 32'(expNv));
`else
        if (expNv === 1'bx) $display("unexpected x flag in %s", tag);
`endif
    endtask

    initial begin
        nrst = 1'b1;
        req  = 1'b0;
        src1 = '0;
        src2 = '0;
        op   = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        checkAll("rst0", 1'b0, 32'h0, 10'h000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        nrst = 1'b0;

        // +1 vs large negative normal
        drive(32'h3f80_0000, 32'hcf80_0000, 2'b00);
        checkAll("v1", 1'b1, 32'hbf80_0000, 10'h040, 32'hcf80_0000, 32'h3f80_0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // qNaN src1: min/max return the number
        drive(32'h7fc0_0000, 32'h3f80_0000, 2'b00);
        checkAll("v2", 1'b1, 32'h7fc0_0000, 10'h200, 32'h3f80_0000, 32'h3f80_0000, 1'b0, 1'b0, 1'b0, 1'b1);

        // -0 vs +0
        drive(32'h8000_0000, 32'h0000_0000, 2'b10);
        checkAll("v3", 1'b1, 32'h8000_0000, 10'h008, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0);

        // +0 vs -0 (min/max order independent of operand position)
        drive(32'h0000_0000, 32'h8000_0000, 2'b00);
        checkAll("v3b", 1'b1, 32'h8000_0000, 10'h010, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0);

        // sNaN and qNaN: canonical NaN
        drive(32'h7f80_0001, 32'hffc0_0000, 2'b01);
        checkAll("v4", 1'b1, 32'h7f80_0001, 10'h100, 32'h7fc0_0000, 32'h7fc0_0000, 1'b0, 1'b0, 1'b0, 1'b1);

        // Number vs sNaN in src2
        drive(32'h3f80_0000, 32'h7fa0_0000, 2'b11);
        checkAll("v4b", 1'b1, 32'h3f80_0000, 10'h040, 32'h3f80_0000, 32'h3f80_0000, 1'b0, 1'b0, 1'b0, 1'b1);

        // -inf vs smallest +subnormal
        drive(32'hff80_0000, 32'h0000_0001, 2'b00);
        checkAll("v6", 1'b1, 32'h7f80_0000, 10'h001, 32'hff80_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b0);

        // Both positive, src1 larger
        drive(32'h4000_0000, 32'h3f80_0000, 2'b00);
        checkAll("v8", 1'b1, 32'h4000_0000, 10'h040, 32'h3f80_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back: equal subnormals, then -subnormal vs +inf, then +0 vs +1
        drive(32'h0040_0000, 32'h0040_0000, 2'b01);
        checkAll("b2b0", 1'b1, 32'h8040_0000, 10'h020, 32'h0040_0000, 32'h0040_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(32'h807f_ffff, 32'h7f80_0000, 2'b10);
        checkAll("b2b1", 1'b1, 32'h807f_ffff, 10'h004, 32'h807f_ffff, 32'h7f80_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(32'h0000_0000, 32'h3f80_0000, 2'b00);
        checkAll("b2b2", 1'b1, 32'h0000_0000, 10'h010, 32'h0000_0000, 32'h3f80_0000, 1'b1, 1'b0, 1'b1, 1'b0);

        // Negative ordering then hold for three idle cycles
        drive(32'hc000_0000, 32'hbf80_0000, 2'b11);
        checkAll("neg", 1'b1, 32'hc000_0000, 10'h002, 32'hc000_0000, 32'hbf80_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            checkAll($sformatf("hold%0d", i), 1'b0, 32'hc000_0000, 10'h002, 32'hc000_0000,
                     32'hbf80_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        end

        // Reset asserted mid-stream while req is high
        @(negedge clk);
        src1 = 32'h3f80_0000;
        src2 = 32'hcf80_0000;
        op   = 2'b00;
        req  = 1'b1;
        #2;
        nrst = 1'b1;
        #1;
        checkAll("rstAsync", 1'b0, 32'h0, 10'h000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkAll("rstHeld", 1'b0, 32'h0, 10'h000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        nrst = 1'b0;
        req  = 1'b0;
        @(posedge clk);
        #1;
        checkVal("rstIdle.ack", 32'(ack), 32'h0);
        drive(32'h7fc0_0000, 32'h3f80_0000, 2'b00);
        checkAll("postRst", 1'b1, 32'h7fc0_0000, 10'h200, 32'h3f80_0000, 32'h3f80_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        checkVal("postRst.ackDrop", 32'(ack), 32'h0);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
